// File: rtl/stream_packetizer_if.sv
// rtl/stream_packetizer_if.sv - AXI-Stream link (tdata/tvalid/tready/tlast) used on both sides of stream_packetizer
interface stream_packetizer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_packetizer.sv
// rtl/stream_packetizer.sv - frames a non-stallable sample stream into TLAST packets through a FIFO
// Optional STREAM_PACKETIZER_PKT_CNT_EN adds a 16-bit completed-packet counter output.
module stream_packetizer #(
  parameter int DATA_W     = 16,
  parameter int COUNT_W    = 25,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [COUNT_W-1:0]  count,
  stream_packetizer_if.slave  s_axis,
  stream_packetizer_if.master m_axis,
  output logic                busy,
  output logic                overflow
`ifdef STREAM_PACKETIZER_PKT_CNT_EN
  ,
  output logic [15:0]         pkt_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               run_en;
  logic [COUNT_W-1:0] cnt_lat;
  logic [COUNT_W-1:0] beat_cnt;
  logic [COUNT_W-1:0] beat_nxt;
  logic               cont_lat;
  logic               stop_seen;

  logic [DATA_W:0]    mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;

  logic               load;
  logic               pop;
  logic               wr_req;
  logic               bypass;
  logic               fifo_wr;
  logic               accept;
  logic               wr_last;
  logic               pkt_end;
  logic               pkt_again;
  logic               start_ok;

  logic               out_valid;
  logic               out_last;
  logic [DATA_W-1:0]  out_data;
  logic               unused_s_tlast;

  assign s_axis.tready  = 1'b1;
  assign unused_s_tlast = s_axis.tlast;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign load     = m_axis.tready || !out_valid;
  assign pop      = load && !empty;
  assign wr_req   = run_en && s_axis.tvalid;
  // An empty FIFO with a free output register forwards the sample directly for one-cycle latency.
  assign bypass   = wr_req && empty && load;
  assign fifo_wr  = wr_req && !bypass && (!full || pop);
  assign accept   = bypass || fifo_wr;
  assign beat_nxt = beat_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
  assign wr_last  = (beat_nxt == cnt_lat);
  assign pkt_end  = accept && wr_last;
  assign pkt_again = cont_lat && !stop_seen && !stop;
  assign start_ok = start && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (pkt_end && !pkt_again) state_nxt = DRAIN;
      DRAIN:   if (empty && !out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    run_en = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lat   <= '0;
      cont_lat  <= 1'b0;
      beat_cnt  <= '0;
      stop_seen <= 1'b0;
    end else if (state == IDLE) begin
      if (start_ok) begin
        cnt_lat   <= count;
        cont_lat  <= continuous;
        beat_cnt  <= '0;
        stop_seen <= 1'b0;
      end
    end else if (run_en) begin
      if (pkt_end) begin
        beat_cnt  <= '0;
        stop_seen <= 1'b0;
      end else begin
        if (accept) beat_cnt <= beat_nxt;
        if (cont_lat && stop) stop_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr[AW-1:0]] <= {wr_last, s_axis.tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (wr_req && !accept) overflow <= 1'b1;
      if (pop) begin
        {out_last, out_data} <= mem[rd_ptr[AW-1:0]];
        out_valid            <= 1'b1;
      end else if (bypass) begin
        out_data  <= s_axis.tdata;
        out_last  <= wr_last;
        out_valid <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;

`ifdef STREAM_PACKETIZER_PKT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_count <= 16'd0;
    else if (out_valid && m_axis.tready && out_last) pkt_count <= pkt_count + 16'd1;
  end
`endif
endmodule
